clock_counter: RTL and testbench

Time-of-day accumulator on the consuming end of the timer interface. It receives the timer's one-cycle end pulse as a tick and counts seconds, minutes and hours with cascaded wrap-around. It drives the timer's stop input while counting is frozen or a new time is being loaded. It sits between the timer and the display/readout logic in the clock subsystem.

---
 rtl/clock_counter.sv | 131 +++++++++++++
 tb/tb_clock_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_counter.sv
// Time-of-day accumulator: counts timer ticks into seconds/minutes/hours with cascaded wrap,
// accepts time loads over a valid/ready handshake and stops the timer while not running.
module clock_counter #(
   parameter int p_seconds = 60,
   parameter int p_minutes = 60,
   parameter int p_hours   = 24
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_tick,
   input  logic                         i_hold,
   input  logic                         i_set_valid,
   input  logic [$clog2(p_seconds)-1:0] i_set_ss,
   input  logic [$clog2(p_minutes)-1:0] i_set_mm,
   input  logic [$clog2(p_hours)-1:0]   i_set_hh,
   output logic                         o_set_ready,
   output logic                         o_set_err,
   output logic                         o_stop,
   output logic [$clog2(p_seconds)-1:0] o_ss,
   output logic [$clog2(p_minutes)-1:0] o_mm,
   output logic [$clog2(p_hours)-1:0]   o_hh,
   output logic                         o_day,
   output logic [1:0]                   o_dbg_state
);

   localparam int S = $clog2(p_seconds);
   localparam int M = $clog2(p_minutes);
   localparam int H = $clog2(p_hours);

   localparam logic [S-1:0] SS_MAX = S'(p_seconds - 1);
   localparam logic [M-1:0] MM_MAX = M'(p_minutes - 1);
   localparam logic [H-1:0] HH_MAX = H'(p_hours - 1);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      LOAD = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [S-1:0]   ss_q, ss_d;
   logic [M-1:0]   mm_q, mm_d;
   logic [H-1:0]   hh_q, hh_d;
   logic           err_q, err_d;
   logic           day_q, day_d;
   logic           set_ready;
   logic           xfer;

   // Handshake: a load transfers on any edge where i_set_valid and o_set_ready are both high;
   // ready is decoded from state only, so it never depends on valid.
   assign set_ready = (state_q != LOAD);
   assign xfer      = i_set_valid && set_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RUN;
         ss_q    <= '0;
         mm_q    <= '0;
         hh_q    <= '0;
         err_q   <= 1'b0;
         day_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ss_q    <= ss_d;
         mm_q    <= mm_d;
         hh_q    <= hh_d;
         err_q   <= err_d;
         day_q   <= day_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (xfer)        state_d = LOAD;
            else if (i_hold) state_d = HOLD;
         end
         HOLD: begin
            if (xfer)         state_d = LOAD;
            else if (!i_hold) state_d = RUN;
         end
         LOAD:    state_d = i_hold ? HOLD : RUN;
         default: state_d = RUN;
      endcase
   end

   // A load in the same cycle as a tick wins; out-of-range fields are forced to zero.
   always_comb begin
      ss_d  = ss_q;
      mm_d  = mm_q;
      hh_d  = hh_q;
      err_d = 1'b0;
      day_d = 1'b0;
      if (xfer) begin
         ss_d  = (i_set_ss > SS_MAX) ? '0 : i_set_ss;
         mm_d  = (i_set_mm > MM_MAX) ? '0 : i_set_mm;
         hh_d  = (i_set_hh > HH_MAX) ? '0 : i_set_hh;
         err_d = (i_set_ss > SS_MAX) || (i_set_mm > MM_MAX) || (i_set_hh > HH_MAX);
      end else if (state_q == RUN && i_tick) begin
         if (ss_q == SS_MAX) begin
            ss_d = '0;
            if (mm_q == MM_MAX) begin
               mm_d = '0;
               if (hh_q == HH_MAX) begin
                  hh_d  = '0;
                  day_d = 1'b1;
               end else begin
                  hh_d = hh_q + 1'b1;
               end
            end else begin
               mm_d = mm_q + 1'b1;
            end
         end else begin
            ss_d = ss_q + 1'b1;
         end
      end
   end

   always_comb begin
      o_set_ready = set_ready;
      o_stop      = (state_q != RUN);
      o_set_err   = err_q;
      o_day       = day_q;
      o_ss        = ss_q;
      o_mm        = mm_q;
      o_hh        = hh_q;
      o_dbg_state = state_q;
   end

endmodule

// File: tb/tb_clock_counter.sv
// Directed bench for clock_counter: one task per scenario, inline checks, single summary line.
module tb_clock_counter;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_tick;
   logic       i_hold;
   logic       i_set_valid;
   logic [5:0] i_set_ss;
   logic [5:0] i_set_mm;
   logic [4:0] i_set_hh;
   logic       o_set_ready;
   logic       o_set_err;
   logic       o_stop;
   logic [5:0] o_ss;
   logic [5:0] o_mm;
   logic [4:0] o_hh;
   logic       o_day;
   logic [1:0] o_dbg_state;

   int total = 0;
   int bad   = 0;

   clock_counter dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_tick      (i_tick),
      .i_hold      (i_hold),
      .i_set_valid (i_set_valid),
      .i_set_ss    (i_set_ss),
      .i_set_mm    (i_set_mm),
      .i_set_hh    (i_set_hh),
      .o_set_ready (o_set_ready),
      .o_set_err   (o_set_err),
      .o_stop      (o_stop),
      .o_ss        (o_ss),
      .o_mm        (o_mm),
      .o_hh        (o_hh),
      .o_day       (o_day),
      .o_dbg_state (o_dbg_state)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_tick();
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_tick = 1'b0; i_hold = 1'b0; i_set_valid = 1'b0;
      i_set_ss = '0; i_set_mm = '0; i_set_hh = '0;
      step(); step();
      i_rst_n = 1'b1;
      step();
      total++;
      if ({o_hh, o_mm, o_ss} !== 17'd0) begin
         bad++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", o_hh, o_mm, o_ss);
      end
      total++;
      if ({o_stop, o_set_ready, o_set_err, o_day} !== 4'b0100) begin
         bad++; $display("FAIL reset_flags got stop/rdy/err/day=%b want 0100",
                         {o_stop, o_set_ready, o_set_err, o_day});
      end
   endtask

   task automatic test_count();
      logic seen_stop = 1'b0;
      logic seen_day  = 1'b0;
      for (int t = 0; t < 61; t++) begin
         do_tick();
         seen_stop |= o_stop; seen_day |= o_day;
         for (int k = 0; k < 4; k++) begin
            step();
            seen_stop |= o_stop; seen_day |= o_day;
         end
      end
      total++;
      if ({o_hh, o_mm, o_ss} !== {5'd0, 6'd1, 6'd1}) begin
         bad++; $display("FAIL count_61 got %0d:%0d:%0d want 0:1:1", o_hh, o_mm, o_ss);
      end
      total++;
      if ({seen_stop, seen_day} !== 2'b00) begin
         bad++; $display("FAIL count_flags got stop/day seen=%b want 00", {seen_stop, seen_day});
      end
   endtask

   task automatic test_day_wrap();
      int day_cycles = 0;
      logic seen_err = 1'b0;
      i_set_valid = 1'b1; i_set_hh = 5'd23; i_set_mm = 6'd59; i_set_ss = 6'd58;
      step();
      i_set_valid = 1'b0;
      seen_err |= o_set_err;
      total++;
      if ({o_set_ready, o_stop, o_dbg_state} !== {1'b0, 1'b1, 2'd2}) begin
         bad++; $display("FAIL load_cycle got rdy/stop/state=%b/%b/%0d want 0/1/2",
                         o_set_ready, o_stop, o_dbg_state);
      end
      step();
      seen_err |= o_set_err;
      do_tick();
      total++;
      if ({o_hh, o_mm, o_ss} !== {5'd23, 6'd59, 6'd59}) begin
         bad++; $display("FAIL wrap_pre got %0d:%0d:%0d want 23:59:59", o_hh, o_mm, o_ss);
      end
      do_tick();
      total++;
      if ({o_hh, o_mm, o_ss, o_day} !== 18'd1) begin
         bad++; $display("FAIL wrap_day got %0d:%0d:%0d day=%b want 0:0:0 day=1",
                         o_hh, o_mm, o_ss, o_day);
      end
      day_cycles = o_day ? 1 : 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (o_day) day_cycles++;
         seen_err |= o_set_err;
      end
      total++;
      if (day_cycles != 1 || seen_err !== 1'b0) begin
         bad++; $display("FAIL day_pulse got day_cycles=%0d err_seen=%b want 1/0",
                         day_cycles, seen_err);
      end
   endtask

   task automatic test_hold();
      logic stop_low = 1'b0;
      logic moved    = 1'b0;
      i_hold = 1'b1;
      step();
      for (int c = 0; c < 20; c++) begin
         i_tick = (c == 3 || c == 10);
         step();
         if (!o_stop) stop_low = 1'b1;
         if ({o_hh, o_mm, o_ss} !== 17'd0) moved = 1'b1;
      end
      i_tick = 1'b0;
      total++;
      if ({stop_low, moved} !== 2'b00) begin
         bad++; $display("FAIL hold_freeze got stop_low/moved=%b want 00", {stop_low, moved});
      end
      i_hold = 1'b0;
      step();
      total++;
      if (o_stop !== 1'b0) begin
         bad++; $display("FAIL hold_release got stop=%b want 0", o_stop);
      end
      do_tick();
      total++;
      if ({o_hh, o_mm, o_ss} !== {5'd0, 6'd0, 6'd1}) begin
         bad++; $display("FAIL hold_resume got %0d:%0d:%0d want 0:0:1", o_hh, o_mm, o_ss);
      end
   endtask

   task automatic test_load_tick();
      int rdy_low = 0;
      i_set_valid = 1'b1; i_tick = 1'b1;
      i_set_hh = 5'd10; i_set_mm = 6'd20; i_set_ss = 6'd30;
      step();
      i_set_valid = 1'b0; i_tick = 1'b0;
      if (!o_set_ready) rdy_low++;
      total++;
      if ({o_hh, o_mm, o_ss} !== {5'd10, 6'd20, 6'd30}) begin
         bad++; $display("FAIL load_tick got %0d:%0d:%0d want 10:20:30", o_hh, o_mm, o_ss);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         if (!o_set_ready) rdy_low++;
      end
      total++;
      if (rdy_low != 1 || {o_hh, o_mm, o_ss} !== {5'd10, 6'd20, 6'd30}) begin
         bad++; $display("FAIL load_ready got rdy_low=%0d time=%0d:%0d:%0d want 1 10:20:30",
                         rdy_low, o_hh, o_mm, o_ss);
      end
   endtask

   task automatic test_load_err();
      i_set_valid = 1'b1;
      i_set_hh = 5'd24; i_set_mm = 6'd61; i_set_ss = 6'd59;
      step();
      i_set_valid = 1'b0;
      total++;
      if ({o_hh, o_mm, o_ss, o_set_err} !== {5'd0, 6'd0, 6'd59, 1'b1}) begin
         bad++; $display("FAIL load_err got %0d:%0d:%0d err=%b want 0:0:59 err=1",
                         o_hh, o_mm, o_ss, o_set_err);
      end
      step();
      total++;
      if (o_set_err !== 1'b0) begin
         bad++; $display("FAIL err_pulse got err=%b want 0", o_set_err);
      end
   endtask

   task automatic test_reset_mid_load();
      i_set_valid = 1'b1;
      i_set_hh = 5'd5; i_set_mm = 6'd6; i_set_ss = 6'd7;
      step();
      i_set_valid = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      total++;
      if ({o_hh, o_mm, o_ss, o_stop, o_set_ready, o_set_err, o_day} !== {17'd0, 4'b0100}) begin
         bad++; $display("FAIL async_reset got %0d:%0d:%0d stop/rdy/err/day=%b want 0:0:0 0100",
                         o_hh, o_mm, o_ss, {o_stop, o_set_ready, o_set_err, o_day});
      end
      step();
      i_rst_n = 1'b1;
      step();
      total++;
      if ({o_hh, o_mm, o_ss} !== 17'd0 || o_dbg_state !== 2'd0 || o_set_ready !== 1'b1) begin
         bad++; $display("FAIL post_reset got %0d:%0d:%0d state=%0d rdy=%b want 0:0:0 0 1",
                         o_hh, o_mm, o_ss, o_dbg_state, o_set_ready);
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_day_wrap();
      test_hold();
      test_load_tick();
      test_load_err();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
